mu0_sync_ram: RTL and testbench

//   Parametrised single-port synchronous word RAM for the MU0 datapath.

---
 rtl/mu0_sync_ram.sv | 148 ++++++++++++++
 tb/tb_mu0_sync_ram.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_sync_ram.sv
// Single-port synchronous word RAM for the MU0 datapath: registered request/ready
// handshake, programmable wait states, optional zeroing sweep after reset, range error flag.
module mu0_sync_ram #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 32,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              mem_rst,
    input  logic              memrq,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_wdata;
    logic                in_range;
    logic [IDX_W-1:0]    addr_idx;

    // Full-width compare so out-of-range addresses never alias onto real words.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign addr_idx = addr_q[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        mem_idx    = clr_ptr_q;
        mem_wdata  = '0;

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + IDX_W'(1);
                end
            end
            S_IDLE: begin
                if (memrq) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    data_d  = in_data;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_DONE;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (rw_q) out_data_d = '0;
                    end else if (rw_q) begin
                        out_data_d = mem[addr_idx];
                    end else begin
                        mem_we    = 1'b1;
                        mem_idx   = addr_idx;
                        mem_wdata = data_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            busy_q     <= (CLEAR_ON_RESET != 0);
            clr_ptr_q  <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            clr_ptr_q  <= clr_ptr_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        rw_q   <= rw_d;
        data_q <= data_d;
    end

    // A write decided in the same cycle as reset is dropped: aborted accesses never commit.
    always_ff @(posedge clk) begin
        if (mem_we && !mem_rst) mem[mem_idx] <= mem_wdata;
    end

    assign out_data = out_data_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mu0_sync_ram.sv
// Bench for mu0_sync_ram: vector table, handshake corner sequences, and random
// accesses checked against an array-based memory model.
module tb_mu0_sync_ram;

    localparam int WS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        mem_rst = 1'b0;
    logic        memrq = 1'b0, rw = 1'b0;
    logic [11:0] addr = '0;
    logic [15:0] in_data = '0;
    logic [15:0] out_data;
    logic        ready, err, busy;

    logic        z_memrq = 1'b0, z_rw = 1'b0;
    logic [11:0] z_addr = '0;
    logic [15:0] z_in_data = '0;
    logic [15:0] z_out_data;
    logic        z_ready, z_err, z_busy;

    mu0_sync_ram #(.DATA_W(16), .ADDR_W(12), .DEPTH(32), .WAIT_STATES(WS), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .mem_rst(mem_rst), .memrq(memrq), .rw(rw), .addr(addr), .in_data(in_data),
        .out_data(out_data), .ready(ready), .err(err), .busy(busy));

    mu0_sync_ram #(.DATA_W(16), .ADDR_W(12), .DEPTH(32), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) dut_z (
        .clk(clk), .mem_rst(mem_rst), .memrq(z_memrq), .rw(z_rw), .addr(z_addr), .in_data(z_in_data),
        .out_data(z_out_data), .ready(z_ready), .err(z_err), .busy(z_busy));

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [32];
    logic [15:0] model_out;

    typedef struct {
        bit          r;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] eo;
        bit          ee;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory semantics from the rules: reads of real words return stored data,
    // out-of-range reads return zero, out-of-range writes are dropped.
    task automatic model_apply(input bit r, input logic [11:0] a, input logic [15:0] d,
                               output logic [15:0] eo, output bit ee);
        ee = (a >= 12'd32);
        if (ee) begin
            if (r) model_out = 16'h0000;
        end else if (r) begin
            model_out = model_mem[a[4:0]];
        end else begin
            model_mem[a[4:0]] = d;
        end
        eo = model_out;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic acc(input bit r, input logic [11:0] a, input logic [15:0] d,
                       output logic [15:0] o, output logic e);
        int k;
        @(negedge clk);
        memrq = 1'b1; rw = r; addr = a; in_data = d;
        @(posedge clk); #1;
        memrq = 1'b0;
        rw = 1'($urandom); addr = 12'($urandom); in_data = 16'($urandom);
        wait_ready(k);
        chk("latency", 32'(k), 32'(WS + 1));
        o = out_data;
        e = err;
        @(posedge clk); #1;
        chk("ready_err_pulse", {30'b0, ready, err}, 32'd0);
    endtask

    task automatic do_reset(input bit hold);
        int n;
        int rdy;
        int k;
        @(negedge clk);
        mem_rst = 1'b1; memrq = 1'b0; z_memrq = 1'b0;
        @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        mem_rst = 1'b0;
        if (hold) begin
            memrq = 1'b1; rw = 1'b0; addr = 12'd3; in_data = 16'hFFFF;
        end
        n = 0;
        rdy = 0;
        while (busy && n < 100) begin
            n++;
            if (ready) rdy++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'd32);
        chk("ready_in_clear", 32'(rdy), 32'd0);
        chk("z_busy_done", 32'(z_busy), 32'd0);
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
        model_out = 16'h0000;
        if (hold) begin
            @(posedge clk); #1;
            memrq = 1'b0;
            wait_ready(k);
            chk("first_idle_latency", 32'(k), 32'(WS + 1));
            chk("first_idle_err", 32'(err), 32'd0);
            @(posedge clk); #1;
            model_mem[3] = 16'hFFFF;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] o, eo;
        logic        e;
        bit          ee;
        bit          r;
        logic [11:0] a;
        logic [15:0] d;

        tbl[0]  = '{1'b0, 12'h005, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 12'h005, 16'h0000, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b0, 12'h020, 16'h1111, 16'hBEEF, 1'b1};
        tbl[3]  = '{1'b1, 12'hFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[4]  = '{1'b1, 12'h000, 16'h0000, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 12'h003, 16'h0000, 16'hFFFF, 1'b0};
        tbl[6]  = '{1'b0, 12'h01F, 16'hABCD, 16'hFFFF, 1'b0};
        tbl[7]  = '{1'b1, 12'h01F, 16'h0000, 16'hABCD, 1'b0};
        tbl[8]  = '{1'b0, 12'h01F, 16'h5A5A, 16'hABCD, 1'b0};
        tbl[9]  = '{1'b1, 12'h01F, 16'h0000, 16'h5A5A, 1'b0};
        tbl[10] = '{1'b1, 12'h020, 16'h0000, 16'h0000, 1'b1};
        tbl[11] = '{1'b1, 12'h005, 16'h0000, 16'hBEEF, 1'b0};

        do_reset(1'b0);

        // Zero-wait-state instance: write then read back.
        @(negedge clk);
        z_memrq = 1'b1; z_rw = 1'b0; z_addr = 12'd5; z_in_data = 16'hBEEF;
        @(posedge clk); #1;
        z_memrq = 1'b0;
        chk("z_ready_at_accept", 32'(z_ready), 32'd0);
        @(posedge clk); #1;
        chk("z_ready_next_edge", 32'(z_ready), 32'd1);
        chk("z_err_write", 32'(z_err), 32'd0);
        @(posedge clk); #1;
        chk("z_ready_drop", 32'(z_ready), 32'd0);
        @(negedge clk);
        z_memrq = 1'b1; z_rw = 1'b1;
        @(posedge clk); #1;
        z_memrq = 1'b0;
        @(posedge clk); #1;
        chk("z_read_ready", 32'(z_ready), 32'd1);
        chk("z_read_data", 32'(z_out_data), 32'hBEEF);
        chk("z_read_err", 32'(z_err), 32'd0);

        for (int i = 0; i < 32; i++) begin
            acc(1'b1, 12'(i), 16'h0000, o, e);
            chk("cleared_word", 32'(o), 32'd0);
        end

        do_reset(1'b1);

        for (int i = 0; i < 12; i++) begin
            acc(tbl[i].r, tbl[i].a, tbl[i].d, o, e);
            model_apply(tbl[i].r, tbl[i].a, tbl[i].d, eo, ee);
            chk($sformatf("tbl%0d_data", i), 32'(o), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].ee));
        end

        // Reset lands while a write of 16'h1234 to word 7 is waiting.
        @(negedge clk);
        memrq = 1'b1; rw = 1'b0; addr = 12'd7; in_data = 16'h1234;
        @(posedge clk); #1;
        memrq = 1'b0;
        do_reset(1'b0);
        acc(1'b1, 12'd7, 16'h0000, o, e);
        chk("aborted_write_word7", 32'(o), 32'd0);

        for (int i = 0; i < 250; i++) begin
            r = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            d = 16'($urandom);
            acc(r, a, d, o, e);
            model_apply(r, a, d, eo, ee);
            chk("rand_data", 32'(o), 32'(eo));
            chk("rand_err", 32'(e), 32'(ee));
        end

        for (int i = 0; i < 32; i++) begin
            acc(1'b1, 12'(i), 16'h0000, o, e);
            model_apply(1'b1, 12'(i), 16'h0000, eo, ee);
            chk("final_word", 32'(o), 32'(eo));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
